// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: streams (a, b) pairs into an external combinational MAC and accumulates a dot product.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b/in_last   operand pair stream (in_last sampled only on handshake)
//   mac_a, mac_b, mac_c                registered operands and accumulator driven to the MAC
//   mac_res                            MAC result, combinational from mac_a/mac_b/mac_c
//   out_valid/out_ready/out_data/out_count   dot-product result stream
module mac_dot_sequencer #(
    parameter int BIT_WIDTH  = 16,
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 7,
    parameter int VEC_LEN    = 8,
    parameter int CNT_WIDTH  = $clog2(VEC_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_a,
    input  logic [BIT_WIDTH-1:0] in_b,
    input  logic                 in_last,
    output logic [BIT_WIDTH-1:0] mac_a,
    output logic [BIT_WIDTH-1:0] mac_b,
    output logic [BIT_WIDTH-1:0] mac_c,
    input  logic [BIT_WIDTH-1:0] mac_res,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_count
);
    typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;
    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(VEC_LEN - 1);
    // The word layout is only checked here; all FP arithmetic belongs to the MAC.
    if (1 + EXP_WIDTH + MANT_WIDTH != BIT_WIDTH || VEC_LEN < 1) begin : g_bad_cfg
        $error("mac_dot_sequencer: inconsistent format or VEC_LEN");
    end
    state_t state, state_next;
    logic [BIT_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] count;
    logic op_valid, hs;
    assign in_ready = (state == ACCUM) && !rst;
    assign hs       = in_valid && in_ready;
    assign mac_c    = acc;
    assign out_data = acc;
    always_comb begin
        state_next = state;
        state_next = (state == ACCUM) ? ((hs && (in_last || count == LAST)) ? DRAIN : ACCUM) :
                     (state == DRAIN) ? DONE :
                     (out_ready ? ACCUM : DONE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            mac_a     <= '0;
            mac_b     <= '0;
            op_valid  <= 1'b0;
            count     <= '0;
            out_valid <= 1'b0;
            out_count <= '0;
        end else begin
            state <= state_next;
            // The last registered pair is folded in during DRAIN, so acc is final on entry to DONE.
            if (op_valid) acc <= mac_res;
            op_valid <= hs;
            if (hs) begin
                mac_a <= in_a;
                mac_b <= in_b;
                count <= count + CNT_WIDTH'(1);
            end
            if (state == DRAIN) begin
                out_valid <= 1'b1;
                out_count <= count;
            end
            if (state == DONE && out_ready) begin
                acc       <= '0;
                count     <= '0;
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer: directed table-driven bench with a bfloat16 MAC model in the loop.
module tb_mac_dot_sequencer;
    logic        clk = 0;
    logic        rst, in_valid, in_ready, in_last, out_valid, out_ready;
    logic [15:0] in_a, in_b, mac_a, mac_b, mac_c, mac_res, out_data;
    logic [2:0]  out_count;
    int checks = 0, errors = 0;

    mac_dot_sequencer #(.BIT_WIDTH(16), .EXP_WIDTH(8), .MANT_WIDTH(7), .VEC_LEN(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_res(mac_res),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count)
    );

    always #5 clk = ~clk;

    function automatic real bf2r(input logic [15:0] x);
        logic [63:0] d;
        if (x[14:0] == 15'd0) return 0.0;
        d = {x[15], 11'(x[14:7]) + 11'd896, x[6:0], 45'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [15:0] r2bf(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 15'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:45]};
    endfunction

    always_comb mac_res = r2bf(bf2r(mac_a) * bf2r(mac_b) + bf2r(mac_c));

    typedef struct {
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        logic [3:0]       last;
        int               n;
        int               bub;
        logic             stray;
        int               hold;
        logic [15:0]      exp_data;
        int               exp_count;
    } vec_t;

    vec_t tv[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vector(input vec_t c);
        logic [15:0] prev;
        for (int i = 0; i < c.n; i++) begin
            if (i > 0) begin
                for (int j = 0; j < c.bub; j++) begin
                    in_valid = 0;
                    in_last  = c.stray;
                    prev     = mac_c;
                    step();
                    if (j > 0) check("bubble_hold_mac_c", 32'(mac_c), 32'(prev));
                end
            end
            in_valid = 1;
            in_a     = c.a[i];
            in_b     = c.b[i];
            in_last  = c.last[i];
            check("in_ready_accum", 32'(in_ready), 1);
            step();
        end
        in_valid = 0;
        in_last  = 0;
        check("drain_in_ready", 32'(in_ready), 0);
        check("drain_out_valid", 32'(out_valid), 0);
        step();
        check("out_valid", 32'(out_valid), 1);
        check("out_data", 32'(out_data), 32'(c.exp_data));
        check("out_count", 32'(out_count), 32'(c.exp_count));
        for (int k = 0; k < c.hold; k++) begin
            step();
            check("hold_out_valid", 32'(out_valid), 1);
            check("hold_out_data", 32'(out_data), 32'(c.exp_data));
            check("hold_out_count", 32'(out_count), 32'(c.exp_count));
            check("hold_in_ready", 32'(in_ready), 0);
        end
        out_ready = 1;
        check("done_in_ready", 32'(in_ready), 0);
        step();
        out_ready = 0;
        check("post_out_valid", 32'(out_valid), 0);
        check("post_acc_zero", 32'(mac_c), 0);
        check("post_in_ready", 32'(in_ready), 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tv[0] = '{a: {16'h4000, 16'h3F80, 16'h4000, 16'h3F80}, b: {16'h3F80, 16'h4040, 16'h4000, 16'h3F80},
                  last: 4'b0000, n: 4, bub: 0, stray: 0, hold: 0, exp_data: 16'h4120, exp_count: 4};
        tv[1] = '{a: {16'h0000, 16'h0000, 16'h4040, 16'h4000}, b: {16'h0000, 16'h0000, 16'h3F80, 16'h4000},
                  last: 4'b0010, n: 2, bub: 0, stray: 0, hold: 0, exp_data: 16'h40E0, exp_count: 2};
        tv[2] = tv[0]; tv[2].bub = 2;
        tv[3] = tv[0]; tv[3].hold = 5;
        tv[4] = tv[0]; tv[4].last = 4'b1000; tv[4].bub = 1; tv[4].stray = 1;
        tv[5] = '{a: {4{16'h3F80}}, b: {4{16'h3F80}},
                  last: 4'b0000, n: 4, bub: 0, stray: 0, hold: 0, exp_data: 16'h4080, exp_count: 4};
        rst = 1; in_valid = 0; in_last = 0; in_a = 0; in_b = 0; out_ready = 0;
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_data", 32'(out_data), 0);
        check("rst_mac_a", 32'(mac_a), 0);
        check("rst_out_count", 32'(out_count), 0);
        rst = 0;
        #1;
        check("rst_release_in_ready", 32'(in_ready), 1);
        for (int t = 0; t < 5; t++) run_vector(tv[t]);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1; in_a = 16'h4000; in_b = 16'h4000;
            step();
        end
        in_valid = 0;
        step();
        check("mid_acc_nonzero", 32'(mac_c != 16'h0), 1);
        rst = 1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 0);
        step();
        check("mid_rst_mac_a", 32'(mac_a), 0);
        check("mid_rst_mac_b", 32'(mac_b), 0);
        check("mid_rst_mac_c", 32'(mac_c), 0);
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_out_data", 32'(out_data), 0);
        check("mid_rst_out_count", 32'(out_count), 0);
        check("mid_rst_in_ready_held", 32'(in_ready), 0);
        rst = 0;
        #1;
        run_vector(tv[5]);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
